// File: rtl/md_pkg.sv
// Shared types and sizing for the multi-cycle multiply/divide unit.
package md_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned MD_ITERS = 32;

   typedef enum logic {
      MULT = 1'b0,
      DIV  = 1'b1
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_t;

endpackage : md_pkg

// File: rtl/mult_div_unit.sv
// Multi-cycle signed MULT/DIV responder for the MIPS control unit.
// Works on operand magnitudes (shift-add / restoring division), then
// applies sign correction in a single FIX step before loading HI/LO.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned ITERS = MD_ITERS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             md_start,
   input  logic             md_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             md_done,
   output logic             div0
);

   localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam int unsigned AW = 2 * WIDTH;

   md_state_t        state;
   md_state_t        state_next;
   logic             busy_next;
   logic             done_next;
   logic             div0_next;

   md_op_t           op_q;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] opnd;
   logic [AW-1:0]    acc;
   logic [CW-1:0]    cnt;

   logic             op_is_div_c;
   logic             div_zero_c;
   logic [WIDTH-1:0] mag_a_c;
   logic [WIDTH-1:0] mag_b_c;
   logic [WIDTH:0]   mul_sum_c;
   logic [AW-1:0]    mul_next_c;
   logic [WIDTH:0]   rem_shift_c;
   logic             div_ge_c;
   logic [WIDTH-1:0] div_diff_c;
   logic [AW-1:0]    div_next_c;
   logic             neg_res_c;
   logic [AW-1:0]    prod_fix_c;
   logic [WIDTH-1:0] quo_fix_c;
   logic [WIDTH-1:0] rem_fix_c;
   logic             last_iter_c;

   // Operand magnitudes, negated in WIDTH+1 bits so -2^(WIDTH-1) survives
   always_comb begin
      op_is_div_c = (md_op_t'(md_op) == DIV);
      div_zero_c  = op_is_div_c && (op_b == '0);
      mag_a_c     = op_a[WIDTH-1] ? WIDTH'(-{1'b1, op_a}) : op_a;
      mag_b_c     = op_b[WIDTH-1] ? WIDTH'(-{1'b1, op_b}) : op_b;
   end

   // One iteration of shift-add multiply and of restoring divide
   always_comb begin
      mul_sum_c   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next_c  = {mul_sum_c, acc[WIDTH-1:1]};
      rem_shift_c = acc[AW-1:WIDTH-1];
      div_ge_c    = (rem_shift_c >= {1'b0, opnd});
      div_diff_c  = WIDTH'(rem_shift_c - {1'b0, opnd});
      div_next_c  = div_ge_c ? {div_diff_c, acc[WIDTH-2:0], 1'b1}
                             : {acc[AW-2:0], 1'b0};
      last_iter_c = (cnt == CW'(ITERS - 1));
   end

   // Sign correction: quotient truncates toward zero, remainder follows dividend
   always_comb begin
      neg_res_c  = sign_a ^ sign_b;
      prod_fix_c = neg_res_c ? -acc : acc;
      quo_fix_c  = neg_res_c ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix_c  = sign_a ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
   end

   // Control state and registered status outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         md_done <= 1'b0;
         div0    <= 1'b0;
      end else begin
         state   <= state_next;
         busy    <= busy_next;
         md_done <= done_next;
         div0    <= div0_next;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      div0_next  = 1'b0;
      unique case (state)
         IDLE: begin
            if (md_start) begin
               if (div_zero_c) begin
                  state_next = DONE;
                  done_next  = 1'b1;
                  div0_next  = 1'b1;
               end else begin
                  state_next = CALC;
               end
            end
         end
         CALC: begin
            if (last_iter_c) begin
               state_next = FIX;
            end
         end
         FIX: begin
            state_next = DONE;
            done_next  = 1'b1;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next == CALC) || (state_next == FIX);
   end

   // Datapath: latch operands on acceptance, iterate, load HI/LO on FIX
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q   <= MULT;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (md_start) begin
                  op_q   <= md_op_t'(md_op);
                  sign_a <= op_a[WIDTH-1];
                  sign_b <= op_b[WIDTH-1];
                  opnd   <= op_is_div_c ? mag_b_c : mag_a_c;
                  acc    <= {{WIDTH{1'b0}}, (op_is_div_c ? mag_a_c : mag_b_c)};
                  cnt    <= '0;
               end
            end
            CALC: begin
               acc <= (op_q == DIV) ? div_next_c : mul_next_c;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               if (op_q == MULT) begin
                  hi <= prod_fix_c[AW-1:WIDTH];
                  lo <= prod_fix_c[WIDTH-1:0];
               end else begin
                  hi <= rem_fix_c;
                  lo <= quo_fix_c;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule : mult_div_unit
